serial_full_adder: RTL and testbench

- Bit-serial N-bit adder built around one full-adder cell and a registered carry; the complement of the team's full subtractor.
- Accepts two operands plus carry-in over a valid/ready handshake.
- Adds LSB-first over WIDTH clock cycles.
- Presents the sum and carry-out on a valid/ready output handshake.
- Serves as the small-area arithmetic path where throughput of one result per WIDTH+2 cycles is sufficient.

---
 rtl/serial_full_adder.sv | 83 ++++++++
 tb/tb_serial_full_adder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial WIDTH-bit adder with one full-adder cell and valid/ready handshakes
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, s, last;
  logic [WIDTH:0] sh;
  always_comb begin
    s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    sh = {s, sum_sr_q};
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    cout_d = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_sr_d = a;
      b_sr_d = b;
      carry_d = cin;
      sum_sr_d = '0;
      cnt_d = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      carry_d = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
      sum_sr_d = sh[WIDTH:1];
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : SHIFT;
      sum_d = last ? sh[WIDTH:1] : sum_q;
      cout_d = last ? carry_d : cout_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q <= '0;
      b_sr_q <= '0;
      sum_sr_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign sum = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: randomized and directed checks of serial_full_adder against plain-arithmetic model
module tb_serial_full_adder;
  logic clk = 0, rst = 1;
  logic iv8 = 0, ci8 = 0, or8 = 0, ir8, ov8, co8, bz8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic iv1 = 0, a1 = 0, b1 = 0, ci1 = 0, or1 = 0, ir1, ov1, s1, co1, bz1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
  );
  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold, input bit pulse);
    logic [8:0] exp;
    int n;
    exp = 9'(a) + 9'(b) + 9'(c);
    check("idle_ready8", ir8, 1);
    a8 = a; b8 = b; ci8 = c; iv8 = 1; or8 = 0;
    tick();
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    n = 0;
    while (!ov8 && n < 50) begin
      check("shift_busy8", {ir8, bz8}, 2'b01);
      if (pulse && n == 3) begin iv8 = 1; a8 = 8'hAA; end
      else iv8 = 0;
      tick();
      n++;
    end
    iv8 = 0;
    check("latency8", n, 8);
    check("result8", {co8, s8}, exp);
    for (int i = 0; i < hold; i++) begin
      iv8 = 1; a8 = 8'hAA;
      tick();
      check("hold_valid8", {ov8, ir8, bz8}, 3'b101);
      check("hold_result8", {co8, s8}, exp);
    end
    iv8 = 0;
    or8 = 1;
    tick();
    or8 = 0;
    check("drain8", {ov8, ir8, bz8}, 3'b010);
    check("persist8", {co8, s8}, exp);
  endtask
  task automatic run1(input logic a, input logic b, input logic c);
    logic [1:0] exp;
    int n;
    exp = 2'(a) + 2'(b) + 2'(c);
    a1 = a; b1 = b; ci1 = c; iv1 = 1; or1 = 1;
    tick();
    iv1 = 0; a1 = ~a; b1 = ~b; ci1 = ~c;
    n = 0;
    while (!ov1 && n < 20) begin tick(); n++; end
    check("latency1", n, 1);
    check("result1", {co1, s1}, exp);
    tick();
    check("drain1", {ov1, ir1}, 2'b01);
  endtask
  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic rc;
    int cyc, last, got, sent, n;
    tick(); tick();
    rst = 0;
    check("rst8", {ir8, ov8, bz8, co8, s8}, {3'b100, 9'h0});
    check("rst1", {ir1, ov1, bz1, co1, s1}, 5'b10000);
    run8(8'h5A, 8'h3C, 0, 0, 0);
    check("sum_5a3c", {co8, s8}, 9'h096);
    run8(8'hFF, 8'h01, 0, 0, 0);
    check("wrap_ff01", {co8, s8}, 9'h100);
    run8(8'hFF, 8'hFF, 1, 0, 0);
    check("wrap_ffff1", {co8, s8}, 9'h1FF);
    run8(8'h10, 8'h20, 1, 5, 1);
    check("bp_1020", {co8, s8}, 9'h031);
    a8 = 8'h7F; b8 = 8'h01; ci8 = 0; iv8 = 1;
    tick();
    iv8 = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    check("midrst", {ov8, ir8, bz8, co8, s8}, {3'b010, 9'h0});
    run8(8'h02, 8'h03, 0, 0, 0);
    check("after_rst", {co8, s8}, 9'h005);
    for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0]);
    iv8 = 1; or8 = 1; cyc = 0; last = -1; got = 0; sent = 0;
    while (got < 1000 && cyc < 20000) begin
      iv8 = sent < 1000;
      if (ov8) begin
        if (q.size() == 0) check("b2b_spurious", 1, 0);
        else begin
          e = q.pop_front();
          check("b2b_res", {co8, s8}, e);
        end
        got++;
      end
      if (ir8 && sent < 1000) begin
        if (last >= 0) check("b2b_gap", cyc - last, 10);
        last = cyc;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        if (sent % 50 == 0) begin ra = 8'hFF; rb = 8'($urandom_range(1, 255)); end
        a8 = ra; b8 = rb; ci8 = rc;
        q.push_back(9'(ra) + 9'(rb) + 9'(rc));
        sent++;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      end
      tick();
      cyc++;
    end
    iv8 = 0; or8 = 0;
    check("b2b_count", got, 1000);
    n = q.size();
    check("b2b_queue_empty", n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
